led_flash_ctrl: RTL
===================

Name: led_flash_ctrl

Overview:
- Sequencer for the LED-flashing datapath.
- Owns a tick prescaler: one-cycle enable every CLK_DIV clocks, the enable form of the divided clock.
- Run sequence on each start: drive an up-counter 0..limit, then flash all LEDs N times, then report done.
- Sits between board buttons/top-level control and the LED pins; the only block that sequences counter and flash timing.

Parameters:
- CLK_DIV, 50000: i_clk cycles per tick; legal range >= 2.
- CNT_W, 4: width of the up-counter and i_limit.
- LED_W, 8: LED output width; must satisfy LED_W >= CNT_W.
- FLASH_W, 4: width of the flash-count input.

Ports:
- i_clk  in  1  system clock.
- i_reset  in  1  asynchronous, active-high reset.
- i_start  in  1  one-cycle pulse; accepted only in IDLE.
- i_stop  in  1  level; aborts a run to IDLE.
- i_pause  in  1  level; freezes prescaler, counter and state.
- i_limit  in  CNT_W  terminal count; sampled on an accepted start.
- i_flash_num  in  FLASH_W  number of on/off flash pairs; sampled on an accepted start.
- o_count  out  CNT_W  current counter value.
- o_led  out  LED_W  LED drive.
- o_busy  out  1  high in COUNT and FLASH.
- o_done  out  1  one-cycle pulse at run completion.

Behaviour:
- Reset (async, immediate on i_reset=1): state=IDLE, prescaler=0, o_count=0, o_led=0, o_busy=0, o_done=0, flash phase=0, latched limit/flash_num=0.
- Tick: prescaler counts 0..CLK_DIV-1 only in COUNT/FLASH with i_pause=0. tick=1 in the cycle the prescaler equals CLK_DIV-1; the prescaler then wraps to 0. The prescaler is cleared on every state entry, so the first tick after any entry arrives exactly CLK_DIV cycles later.
- IDLE:
  - On i_start=1 and i_stop=0: latch i_limit and i_flash_num; next cycle state=COUNT, o_count=0, o_busy=1.
  - i_start outside IDLE is ignored.
- COUNT:
  - On tick with o_count<limit: o_count+1.
  - On tick with o_count==limit: go to FLASH if flash_num!=0, else DONE.
  - limit=0: leaves COUNT on the first tick.
  - The counter never wraps past limit.
  - o_led = o_count zero-extended to LED_W.
- FLASH:
  - Each tick toggles the phase bit. o_led = {LED_W{phase}}; o_count holds at limit.
  - A pair counter increments on each 1->0 phase toggle; when it reaches flash_num, the state goes to DONE on that same tick.
  - Total time in FLASH = 2*flash_num ticks.
- DONE (one cycle): o_done=1, o_busy=0, o_led=0; next state IDLE. o_count holds its final value until the next start.
- Pause: i_pause=1 in COUNT/FLASH freezes everything; outputs hold and o_busy stays 1. Resuming continues with the remaining prescaler count (no restart). Pause in IDLE/DONE has no effect.
- Stop: i_stop=1 in any non-IDLE state forces IDLE next cycle with o_count=0, o_led=0, o_busy=0, and no o_done pulse.
- Priority when signals coincide: i_stop > i_pause > tick. i_start together with i_stop in IDLE is ignored.
- All outputs are registered.

Optional Feature:
- Macro LED_FLASH_GRAY_EN.
- When defined: o_count and the COUNT-state o_led carry the Gray code of the internal binary counter (bin ^ bin>>1). The internal compare against limit stays binary.
- When undefined: plain binary output.
- Timing and states are identical either way.

Decomposition:
- Shared package led_flash_pkg holds:
  - state enum: IDLE, COUNT, FLASH, DONE (2-bit encoding);
  - default CLK_DIV constant;
  - simulation CLK_DIV constant, 4.
- Natural sub-module: tick_gen. It contains the prescaler, with inputs i_clk, i_reset, i_en, i_clr and output o_tick.

Test Plan (CLK_DIV=4, CNT_W=4, LED_W=8):
- Basic run: start, limit=3, flash_num=2 -> o_count 0,1,2,3 at 4-cycle spacing; o_led alternates 0xFF/0x00 for 4 ticks; o_done pulses once exactly 4*(3+1)+4*4 cycles after COUNT entry; o_busy drops the same cycle.
- Edge values: limit=0, flash_num=0 -> COUNT lasts one tick, no FLASH, o_done 4 cycles after COUNT entry.
- Pause: i_pause held 10 cycles mid-COUNT at o_count=2 -> o_count holds 2 and o_busy=1; the next increment lands after the remaining prescaler cycles; total run extends by exactly 10 cycles.
- Stop vs pause: i_stop during FLASH with i_pause=1 -> IDLE next cycle, o_led=0, o_count=0, no o_done. i_start with i_stop in IDLE -> stays IDLE.
- Async reset mid-run: assert i_reset between clock edges -> all outputs 0 immediately. A start mid-run is ignored, and the latched limit is unchanged.
- With LED_FLASH_GRAY_EN: limit=7 -> o_count sequence 0,1,3,2,6,7,5,4.

Source files
------------

// File: rtl/led_flash_pkg.sv
// ---------------------------------------------------------------------------
// led_flash_pkg
// Shared definitions for the LED-flash sequencer:
//   state_t          - sequencer state encoding (2 bits)
//   CLK_DIV_DEFAULT  - prescaler divide ratio for the real board clock
//   CLK_DIV_SIM      - short divide ratio for simulation
// ---------------------------------------------------------------------------
package led_flash_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    FLASH = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int CLK_DIV_DEFAULT = 50000;
  localparam int CLK_DIV_SIM     = 4;

endpackage

// File: rtl/led_flash_ctrl_tick_gen.sv
// ---------------------------------------------------------------------------
// tick_gen
// Prescaler that produces a one-cycle enable every CLK_DIV clocks while
// enabled. A clear restarts the count so the next tick lands exactly
// CLK_DIV cycles later; while disabled the count is frozen.
// Ports:
//   i_clk   - system clock
//   i_reset - asynchronous active-high reset
//   i_en    - advance the prescaler this cycle
//   i_clr   - restart the prescaler at 0 (wins over i_en)
//   o_tick  - high in the enabled cycle where the prescaler is at CLK_DIV-1
// ---------------------------------------------------------------------------
module tick_gen
  import led_flash_pkg::*;
#(
  parameter int CLK_DIV = CLK_DIV_DEFAULT
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_en,
  input  logic i_clr,
  output logic o_tick
);

  localparam int PW = $clog2(CLK_DIV);
  localparam logic [PW-1:0] LAST = PW'(CLK_DIV - 1);

  logic [PW-1:0] cnt_q;
  logic [PW-1:0] cnt_d;

  assign o_tick = i_en && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (i_clr) begin
      cnt_d = '0;
    end else if (i_en) begin
      cnt_d = o_tick ? '0 : cnt_q + PW'(1);
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/led_flash_ctrl.sv
// ---------------------------------------------------------------------------
// led_flash_ctrl
// Sequencer for the LED-flashing datapath. On an accepted start it counts
// 0..limit (one step per tick), then flashes all LEDs flash_num times
// (on/off pairs), then pulses o_done for one cycle and returns to IDLE.
// Optional build macro: LED_FLASH_GRAY_EN - when defined, o_count and the
// COUNT-state LED pattern carry the Gray code of the internal binary counter.
// Ports:
//   i_clk, i_reset  - clock, asynchronous active-high reset
//   i_start         - one-cycle start pulse, accepted only in IDLE
//   i_stop          - level, aborts a run back to IDLE
//   i_pause         - level, freezes prescaler, counter and state
//   i_limit         - terminal count, sampled on an accepted start
//   i_flash_num     - number of flash pairs, sampled on an accepted start
//   o_count         - current counter value
//   o_led           - LED drive
//   o_busy          - high in COUNT and FLASH
//   o_done          - one-cycle pulse at run completion
// All outputs are registered.
// ---------------------------------------------------------------------------
module led_flash_ctrl
  import led_flash_pkg::*;
#(
  parameter int CLK_DIV = CLK_DIV_DEFAULT,
  parameter int CNT_W   = 4,
  parameter int LED_W   = 8,
  parameter int FLASH_W = 4
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_start,
  input  logic               i_stop,
  input  logic               i_pause,
  input  logic [CNT_W-1:0]   i_limit,
  input  logic [FLASH_W-1:0] i_flash_num,
  output logic [CNT_W-1:0]   o_count,
  output logic [LED_W-1:0]   o_led,
  output logic               o_busy,
  output logic               o_done
);

  state_t state_q, state_d;

  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]   limit_q, limit_d;
  logic [FLASH_W-1:0] flash_num_q, flash_num_d;
  logic [FLASH_W-1:0] pair_q, pair_d;
  logic               phase_q, phase_d;

  logic [CNT_W-1:0]   count_q, count_d;
  logic [LED_W-1:0]   led_q, led_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic               running;
  logic               start_ok;
  logic               at_limit;
  logic               last_pair;
  logic               tick;
  logic               tick_en;
  logic               tick_clr;
  logic [CNT_W-1:0]   disp_d;

  assign running   = (state_q == COUNT) || (state_q == FLASH);
  assign start_ok  = (state_q == IDLE) && i_start && !i_stop;
  assign at_limit  = (cnt_q == limit_q);
  // A pair completes on the 1->0 phase toggle; compare one bit wider so
  // pair+1 cannot wrap.
  assign last_pair = phase_q &&
                     ((FLASH_W+1)'(pair_q) + (FLASH_W+1)'(1) == (FLASH_W+1)'(flash_num_q));

  // Stop outranks pause, and pause outranks tick, so neither may advance
  // the prescaler. Any state change restarts it.
  assign tick_en  = running && !i_pause && !i_stop;
  assign tick_clr = (state_d != state_q);

  tick_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_tick_gen (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_en    (tick_en),
    .i_clr   (tick_clr),
    .o_tick  (tick)
  );

  // State register
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; tick is already gated off by pause and stop
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start_ok) state_d = COUNT;
      end
      COUNT: begin
        if (i_stop) begin
          state_d = IDLE;
        end else if (tick && at_limit) begin
          state_d = (flash_num_q != '0) ? FLASH : DONE;
        end
      end
      FLASH: begin
        if (i_stop) begin
          state_d = IDLE;
        end else if (tick && last_pair) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Datapath: counter, latched run parameters, flash phase and pair count
  always_comb begin
    cnt_d       = cnt_q;
    limit_d     = limit_q;
    flash_num_d = flash_num_q;
    phase_d     = phase_q;
    pair_d      = pair_q;
    if (start_ok) begin
      limit_d     = i_limit;
      flash_num_d = i_flash_num;
      cnt_d       = '0;
      phase_d     = 1'b0;
      pair_d      = '0;
    end else if ((state_q != IDLE) && i_stop) begin
      cnt_d   = '0;
      phase_d = 1'b0;
      pair_d  = '0;
    end else if (tick) begin
      if ((state_q == COUNT) && !at_limit) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
      if (state_q == FLASH) begin
        phase_d = ~phase_q;
        if (phase_q) pair_d = pair_q + FLASH_W'(1);
      end
    end
  end

`ifdef LED_FLASH_GRAY_EN
  assign disp_d = cnt_d ^ (cnt_d >> 1);
`else
  assign disp_d = cnt_d;
`endif

  // Output logic, computed from next-state values so the registered
  // outputs line up with the state they describe
  always_comb begin
    count_d = disp_d;
    busy_d  = (state_d == COUNT) || (state_d == FLASH);
    done_d  = (state_d == DONE);
    led_d   = '0;
    case (state_d)
      COUNT:   led_d = LED_W'(disp_d);
      FLASH:   led_d = {LED_W{phase_d}};
      default: led_d = '0;
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      cnt_q       <= '0;
      limit_q     <= '0;
      flash_num_q <= '0;
      phase_q     <= 1'b0;
      pair_q      <= '0;
      count_q     <= '0;
      led_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      limit_q     <= limit_d;
      flash_num_q <= flash_num_d;
      phase_q     <= phase_d;
      pair_q      <= pair_d;
      count_q     <= count_d;
      led_q       <= led_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign o_count = count_q;
  assign o_led   = led_q;
  assign o_busy  = busy_q;
  assign o_done  = done_q;

endmodule
